// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue:
// instruction length encoding and the opcodes of the long V850 forms.
package ifetch_pkg;

    localparam int HW_W = 16;

    typedef enum logic [1:0] {
        LEN16 = 2'd0,
        LEN32 = 2'd1,
        LEN48 = 2'd2,
        LEN64 = 2'd3
    } inst_len_e;

    // 48-bit forms (MOV imm32 and the 48-bit jump form) and the 64-bit form
    localparam logic [5:0] OP_MOV48 = 6'b110001;
    localparam logic [5:0] OP_JMP48 = 6'b110111;
    localparam logic [5:0] OP_LD64  = 6'b111101;

    function automatic logic [2:0] LEN_HW(inst_len_e len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/ifetch_len_dec.sv
// Combinational V850 instruction length decode from the first halfword.
module ifetch_len_dec
    import ifetch_pkg::*;
(
    input  logic [HW_W-1:0] hw_i,
    output inst_len_e       len_o
);

    logic [5:0] opcode;
    logic       reg2_zero;

    assign opcode    = hw_i[10:5];
    assign reg2_zero = (hw_i[15:11] == 5'd0);

    always_comb begin
        len_o = LEN16;
        if (hw_i[10:9] != 2'b11) begin
            if (reg2_zero && hw_i[9] && hw_i[7]) len_o = LEN32;
        end else if (reg2_zero && (opcode == OP_MOV48 || opcode == OP_JMP48)) begin
            len_o = LEN48;
        end else if (reg2_zero && opcode == OP_LD64) begin
            len_o = LEN64;
        end else begin
            len_o = LEN32;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Multi-outstanding block fetcher feeding a circular halfword queue; presents
// whole decoded-length instructions at the head and handles branch redirects.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int              PC_W      = 25,
    parameter int              MEM_W     = 64,
    parameter int              QDEPTH    = 16,
    parameter int              MAX_OUTST = 2,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_i,
    input  logic [PC_W-1:0]  redirect_pc_i,
    output logic             mem_req_o,
    output logic [PC_W-1:0]  mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [MEM_W-1:0] mem_rdata_i,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [63:0]      inst_o,
    output logic [1:0]       inst_len_o,
    output logic [PC_W-1:0]  inst_pc_o
);

    localparam int         HPB     = MEM_W / HW_W;
    localparam int         LOG_HPB = $clog2(HPB);
    localparam int         QA_W    = $clog2(QDEPTH);
    localparam int         PTR_W   = QA_W + 1;
    localparam int         CW      = PTR_W + 2;
    localparam logic [1:0] MAX_O   = 2'(MAX_OUTST);

    logic [HW_W-1:0]    queue_q [QDEPTH];
    logic [HW_W-1:0]    queue_d [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [1:0]         outst_q, outst_d, stale_q, stale_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
    logic [LOG_HPB-1:0] skip_q, skip_d;
    logic [CW-1:0]      free_w, need_w;
    logic [HW_W-1:0]    head_hw [4];
    logic [63:0]        head_inst;
    logic [2:0]         len_hw;
    inst_len_e          head_len;
    logic               grant, xfer, beat_ok;

    // Every in-flight request reserves a full beat of space, so the queue cannot overflow.
    assign count  = wr_ptr_q - rd_ptr_q;
    assign free_w = CW'(QDEPTH) - {2'b00, count};
    assign need_w = ({{(CW-2){1'b0}}, outst_q} + CW'(1)) << LOG_HPB;

    assign mem_req_o  = rst_n & ~redirect_i & (free_w >= need_w) & (outst_q < MAX_O);
    assign mem_addr_o = fetch_pc_q;
    assign grant      = mem_req_o & mem_gnt_i;

    always_comb begin
        for (int k = 0; k < 4; k++) head_hw[k] = queue_q[rd_ptr_q[QA_W-1:0] + QA_W'(k)];
    end

    ifetch_len_dec u_len_dec (
        .hw_i  (head_hw[0]),
        .len_o (head_len)
    );

    assign len_hw = LEN_HW(head_len);

    always_comb begin
        head_inst = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < len_hw) head_inst[k*HW_W +: HW_W] = head_hw[k];
        end
    end

    assign inst_valid_o = rst_n & ~redirect_i & (count >= PTR_W'(len_hw));
    assign inst_o       = inst_valid_o ? head_inst : 64'd0;
    assign inst_len_o   = inst_valid_o ? head_len : LEN16;
    assign inst_pc_o    = head_pc_q;

    assign xfer    = inst_valid_o & inst_ready_i;
    assign beat_ok = mem_rvalid_i & ~redirect_i & (stale_q == 2'd0);

    always_comb begin
        queue_d    = queue_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        skip_d     = skip_q;
        stale_d    = stale_q;
        outst_d    = outst_q + {1'b0, grant} - {1'b0, mem_rvalid_i};
        if (mem_rvalid_i && stale_q != 2'd0) stale_d = stale_q - 2'd1;
        // First beat after a redirect starts mid-block: leading halfwords are skipped.
        if (beat_ok) begin
            for (int i = 0; i < HPB; i++) begin
                if (LOG_HPB'(i) >= skip_q)
                    queue_d[wr_ptr_q[QA_W-1:0] + QA_W'(i) - QA_W'(skip_q)] = mem_rdata_i[i*HW_W +: HW_W];
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(HPB) - PTR_W'(skip_q);
            skip_d   = '0;
        end
        if (grant) fetch_pc_d = fetch_pc_q + PC_W'(HPB);
        if (xfer) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(len_hw);
            head_pc_d = head_pc_q + PC_W'(len_hw);
        end
        // Everything still in flight becomes stale, including beats of earlier redirects.
        if (redirect_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            outst_d    = outst_q - {1'b0, mem_rvalid_i};
            stale_d    = outst_q - {1'b0, mem_rvalid_i};
            fetch_pc_d = {redirect_pc_i[PC_W-1:LOG_HPB], {LOG_HPB{1'b0}}};
            skip_d     = redirect_pc_i[LOG_HPB-1:0];
            head_pc_d  = redirect_pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            outst_q    <= '0;
            stale_q    <= '0;
            fetch_pc_q <= {RESET_PC[PC_W-1:LOG_HPB], {LOG_HPB{1'b0}}};
            skip_q     <= RESET_PC[LOG_HPB-1:0];
            head_pc_q  <= RESET_PC;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            outst_q    <= outst_d;
            stale_q    <= stale_d;
            fetch_pc_q <= fetch_pc_d;
            skip_q     <= skip_d;
            head_pc_q  <= head_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        queue_q <= queue_d;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order memory model with random grant/latency and an
// instruction-stream reference computed straight from the memory image.
module tb_ifetch_queue;

    localparam int PC_W = 25;
    localparam int MASK = (1 << PC_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            redirect_i;
    logic [PC_W-1:0] redirect_pc_i;
    logic            mem_req_o;
    logic [PC_W-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [63:0]     mem_rdata_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [63:0]     inst_o;
    logic [1:0]      inst_len_o;
    logic [PC_W-1:0] inst_pc_o;

    ifetch_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_len_o    (inst_len_o),
        .inst_pc_o     (inst_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hw;
        logic [1:0]  len;
    } len_vec_t;

    len_vec_t    vec [12];
    int          checks = 0, errors = 0, cyc = 0, xfers = 0;
    int          exp_pc, gnt_pct, rv_pct, first_rv_cyc, first_v_cyc, x0, n;
    int          pend_a[$];
    int          pend_c[$];
    logic [15:0] img [int];
    bit          hold_chk, watch_req, found;
    int          watch_addr;
    logic [63:0] hold_inst;
    logic [1:0]  hold_len;
    logic [PC_W-1:0] hold_pc;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] img_hw(int a);
        logic [31:0] h;
        if (img.exists(a)) return img[a];
        h = a * 32'h9E3779B1;
        h = h ^ (h >> 15);
        return h[15:0];
    endfunction

    function automatic logic [63:0] blk(int a);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = img_hw(a + i);
        return r;
    endfunction

    // Halfword count of the instruction starting with h, straight from the ISA rules.
    function automatic int ref_len_hw(logic [15:0] h);
        int op, r2;
        op = int'(h[10:5]);
        r2 = int'(h[15:11]);
        if (op < 48) return (r2 == 0 && h[9] && h[7]) ? 2 : 1;
        if (r2 == 0 && (op == 49 || op == 55)) return 3;
        if (r2 == 0 && op == 61) return 4;
        return 2;
    endfunction

    function automatic logic [63:0] exp_inst(int pc);
        logic [63:0] r = '0;
        int l = ref_len_hw(img_hw(pc));
        for (int k = 0; k < l; k++) r[16*k +: 16] = img_hw((pc + k) & MASK);
        return r;
    endfunction

    // One clock: called at a falling edge with this cycle's inputs already set.
    task automatic cycle();
        int l;
        #1;
        if (redirect_i) begin
            chk("redir_valid", 64'(inst_valid_o), 64'd0);
            chk("redir_req", 64'(mem_req_o), 64'd0);
        end
        if (hold_chk && !redirect_i) begin
            chk("hold_valid", 64'(inst_valid_o), 64'd1);
            chk("hold_inst", inst_o, hold_inst);
            chk("hold_len", 64'(inst_len_o), 64'(hold_len));
            chk("hold_pc", 64'(inst_pc_o), 64'(hold_pc));
        end
        hold_chk  = inst_valid_o && !inst_ready_i && !redirect_i;
        hold_inst = inst_o;
        hold_len  = inst_len_o;
        hold_pc   = inst_pc_o;
        if (inst_valid_o && first_v_cyc < 0) first_v_cyc = cyc;
        if (inst_valid_o && inst_ready_i) begin
            l = ref_len_hw(img_hw(exp_pc));
            chk("xfer_pc", 64'(inst_pc_o), 64'(exp_pc));
            chk("xfer_len", 64'(inst_len_o), 64'(l - 1));
            chk("xfer_inst", inst_o, exp_inst(exp_pc));
            exp_pc = (exp_pc + l) & MASK;
            xfers++;
        end
        if (redirect_i) exp_pc = int'(redirect_pc_i);
        mem_gnt_i = (int'($urandom_range(99)) < gnt_pct);
        if (mem_req_o && mem_gnt_i) begin
            if (watch_req) begin
                chk("redir_first_addr", 64'(mem_addr_o), 64'(watch_addr));
                watch_req = 0;
            end
            pend_a.push_back(int'(mem_addr_o));
            pend_c.push_back(cyc);
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (pend_a.size() > 0 && pend_c[0] < cyc && int'($urandom_range(99)) < rv_pct) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = blk(pend_a[0]);
            void'(pend_a.pop_front());
            void'(pend_c.pop_front());
            if (first_rv_cyc < 0) first_rv_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic redirect(int pc);
        redirect_i    = 1'b1;
        redirect_pc_i = PC_W'(pc);
        cycle();
        redirect_i    = 1'b0;
    endtask

    task automatic wait_valid(string name);
        int k = 0;
        inst_ready_i = 1'b0;
        #1;
        while (!inst_valid_o && k < 60) begin
            cycle();
            #1;
            k++;
        end
        chk(name, 64'(inst_valid_o), 64'd1);
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
        chk({tag, "_inst"}, inst_o, 64'd0);
        chk({tag, "_len"}, 64'(inst_len_o), 64'd0);
        chk({tag, "_pc"}, 64'(inst_pc_o), 64'd0);
    endtask

    task automatic clear_tb_state();
        pend_a.delete();
        pend_c.delete();
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b0;
        redirect_i   = 1'b0;
        exp_pc       = 0;
        hold_chk     = 0;
        first_rv_cyc = -1;
        first_v_cyc  = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{16'h0060, 2'd0};
        vec[1]  = '{16'h0620, 2'd2};
        vec[2]  = '{16'h0720, 2'd1};
        vec[3]  = '{16'h06E0, 2'd2};
        vec[4]  = '{16'h07A0, 2'd3};
        vec[5]  = '{16'h0FA0, 2'd1};
        vec[6]  = '{16'h0E20, 2'd1};
        vec[7]  = '{16'h0280, 2'd1};
        vec[8]  = '{16'h0A80, 2'd0};
        vec[9]  = '{16'h0200, 2'd0};
        vec[10] = '{16'hFFFF, 2'd1};
        vec[11] = '{16'h0000, 2'd0};

        rst_n = 1'b0; redirect_pc_i = '0; mem_rdata_i = '0; inst_ready_i = 1'b0;
        watch_req = 0; watch_addr = 0;
        clear_tb_state();
        gnt_pct = 100; rv_pct = 100;
        img[0] = 16'h0060;
        for (int a = 1; a < 12; a++) img[a] = 16'h0000;

        // Reset state, then four 16-bit instructions from PC 0 with 1-cycle response visibility
        repeat (2) @(negedge clk);
        #1 chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        inst_ready_i = 1'b1;
        x0 = xfers;
        repeat (8) cycle();
        chk("t1_valid_latency", 64'(first_v_cyc - first_rv_cyc), 64'd1);
        chk("t1_progress", 64'(xfers - x0 >= 4), 64'd1);

        // 48-bit MOV at a block start, then a 32-bit instruction straddling two beats
        img[12'h200] = 16'h0620; img[12'h201] = 16'h1234; img[12'h202] = 16'h5678;
        img[12'h203] = 16'h0720; img[12'h204] = 16'hABCD;
        for (int a = 12'h205; a < 12'h208; a++) img[a] = 16'h0000;
        inst_ready_i = 1'b0;
        redirect(12'h200);
        wait_valid("t2_wait");
        chk("t2_len", 64'(inst_len_o), 64'd2);
        chk("t2_inst", inst_o, 64'h0000_5678_1234_0620);
        inst_ready_i = 1'b1;
        cycle();
        wait_valid("t2_wait2");
        chk("t2_pc2", 64'(inst_pc_o), 64'h203);
        chk("t2_inst2", inst_o, 64'h0000_0000_ABCD_0720);

        // Length decode table, each entry placed at a differently skewed PC
        for (int i = 0; i < 12; i++) begin
            n = 32'h1000 + 64 * i + (i % 4);
            img[n] = vec[i].hw;
            redirect(n);
            wait_valid($sformatf("vec%0d_wait", i));
            chk($sformatf("vec%0d_len", i), 64'(inst_len_o), 64'(vec[i].len));
            chk($sformatf("vec%0d_pc", i), 64'(inst_pc_o), 64'(n));
        end

        // Decoder stall: requests must stop, outputs hold, order survives release
        inst_ready_i = 1'b0;
        redirect(12'h300);
        repeat (10) cycle();
        #1 chk("stall_req_off", 64'(mem_req_o), 64'd0);
        inst_ready_i = 1'b1;
        x0 = xfers;
        repeat (20) cycle();
        chk("stall_progress", 64'(xfers > x0), 64'd1);

        // Redirect to 0x105 while two requests are in flight
        rv_pct = 0;
        redirect(12'h500);
        repeat (4) cycle();
        chk("t5_outst", 64'(pend_a.size()), 64'd2);
        watch_req = 1; watch_addr = 12'h104;
        redirect(12'h105);
        rv_pct = 100;
        x0 = xfers;
        repeat (20) cycle();
        chk("t5_req_seen", 64'(watch_req), 64'd0);
        chk("t5_progress", 64'(xfers > x0), 64'd1);

        // Redirect coinciding with a would-be transfer and a response beat
        inst_ready_i = 1'b1;
        redirect(12'h600);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            #1;
            if (inst_valid_o && pend_a.size() > 0 && pend_c[0] < cyc) found = 1;
            else cycle();
        end
        chk("t6_setup", 64'(found), 64'd1);
        x0 = xfers;
        redirect(12'h700);
        chk("t6_no_xfer", 64'(xfers), 64'(x0));
        repeat (20) cycle();
        chk("t6_progress", 64'(xfers > x0), 64'd1);

        // Asynchronous reset in the middle of a burst
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("async_rst");
        clear_tb_state();
        @(negedge clk);
        rst_n = 1'b1;
        x0 = xfers;
        repeat (12) cycle();
        chk("post_rst_progress", 64'(xfers - x0 >= 4), 64'd1);

        // Random traffic against the image-derived instruction stream
        gnt_pct = 70; rv_pct = 60;
        x0 = xfers;
        for (int k = 0; k < 3000; k++) begin
            inst_ready_i = (int'($urandom_range(99)) < 70);
            if (int'($urandom_range(99)) < 2) redirect(int'($urandom_range(MASK)));
            else cycle();
        end
        chk("rand_progress", 64'(xfers - x0 > 500), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Parametrised successor to the single-beat instruction fetcher. Fetches aligned MEM_W-bit blocks over a request/grant/response memory port, with up to MAX_OUTST requests in flight, into a circular halfword prefetch queue. Decodes V850 instruction length (16/32/48/64 bit) at the queue head and presents whole instructions to decode with a valid/ready handshake. Supports branch redirect with queue flush and discard of stale in-flight responses; sits between the I-memory port and the decoder.

Parameters:
PC_W, 25, halfword-address width of PCs
MEM_W, 64, fetch block width in bits; HPB = MEM_W/16 halfwords per beat, power of two, >=4
QDEPTH, 16, queue depth in halfwords, power of two, >= 2*HPB
MAX_OUTST, 2, max outstanding memory requests, 1..3
RESET_PC, 0, halfword PC fetched after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  PC_W  new halfword PC
mem_req_o  out  1  fetch request
mem_addr_o  out  PC_W  block-aligned halfword address (low log2(HPB) bits zero)
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  response beat valid, in request order
mem_rdata_i  in  MEM_W  block data, halfword 0 in [15:0]
inst_valid_o  out  1  whole instruction at head
inst_ready_i  in  1  decoder accepts
inst_o  out  64  instruction, halfword 0 in [15:0], zero above length
inst_len_o  out  2  0=16,1=32,2=48,3=64 bit
inst_pc_o  out  PC_W  halfword PC of instruction

Behaviour:
- Clock clk, reset rst_n asynchronous active-low. Reset: queue empty, outstanding=0, stale=0, fetch_pc=RESET_PC aligned down, skip=RESET_PC low bits, head_pc=RESET_PC; mem_req_o=0, inst_valid_o=0, inst_o=0, inst_len_o=0, inst_pc_o=RESET_PC. Reset mid-transaction drops everything; responses to pre-reset requests are the memory's responsibility.
- Request: mem_req_o = (free_hw >= (outstanding+1)*HPB) & (outstanding < MAX_OUTST) & ~redirect_i. Request+gnt: fetch_pc += HPB (wraps mod 2^PC_W), outstanding++.
- Response: if stale>0, beat dropped, stale--. Else halfwords skip..HPB-1 written in order, skip cleared; outstanding-- on every beat. Grant and response in the same cycle leave outstanding unchanged.
- Length decode on head halfword h (h[10:5]=opcode, h[15:11]=reg2):
  h[10:9]!=11: 32 if reg2==0 & h[9] & h[7], else 16.
  h[10:5]==110001 or 110111 with reg2==0: 48.
  h[10:5]==111101 with reg2==0: 64.
  other h[10:9]==11: 32.
- inst_valid_o = (count >= len) & ~redirect_i; inst_* driven combinationally from queue registers. Beat written at edge N -> instruction visible cycle N+1.
- Transfer on valid & ready: rd_ptr += len, head_pc += len. Simultaneous write and read in one cycle allowed; count updates by both.
- inst_* hold stable while valid & ~ready.
- Redirect (priority over everything): same-cycle handshake void, no write. Next cycle: queue empty, fetch_pc = redirect_pc_i aligned down, skip = low bits, head_pc = redirect_pc_i, stale = outstanding - (rvalid this cycle ? 1 : 0). Redirect during stale draining accumulates correctly.
- Queue pointers carry one extra wrap bit; full = QDEPTH halfwords, never overflows by construction of the request rule.

Decomposition:
- ifetch_pkg: inst_len_e enum, HW_W=16, LEN_HW(len) function, opcode constants for 48/64-bit forms.
- Sub-module ifetch_len_dec: combinational halfword -> inst_len_e. The queue stays in the top.

Test Plan:
- Reset, RESET_PC=0, memory returns 0x0000_0000_0000_0060 then zeros -> four 16-bit instructions, PCs 0,1,2,3, first valid 1 cycle after first rvalid.
- Block with halfword0=0x0620, halfword1=0x1234 (MOV imm32 form) plus following block -> inst_len_o=2, inst_pc_o=0, next instruction at PC 3 spans the block boundary.
- inst_ready_i low 10 cycles -> mem_req_o drops once free_hw < HPB*(outstanding+1); no overflow; outputs held; order intact on release.
- Redirect to PC 0x105 with 2 requests outstanding -> both old beats dropped, first fetch address 0x104, halfword 0 of that beat skipped, first inst_pc_o=0x105.
- Redirect in the same cycle as valid & ready and rvalid -> no transfer counted, stale=outstanding-1, no old data delivered.
- Assert rst_n low mid-burst -> all outputs reach reset values without a clock edge.
